// File: rtl/func_sweep_checker_pkg.sv
// Shared types and constants for the func_sweep_checker block.
//   state_t  : sweep controller states
//   VEC_W    : width of the function input vector
//   NUM_VEC  : number of input vectors in one sweep
//   CNT_W    : width of the mismatch counter (holds 0..NUM_VEC)
//   TMR_W    : width of the settle counter (SETTLE legal range 1..15)
//   F_TRUTH  : golden truth table of F = A(CD + B) + BC', bit i = F({A,B,C,D} = i)
package func_sweep_checker_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TMR_W   = 4;

  localparam logic [NUM_VEC-1:0] F_TRUTH = 16'hF830;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/func_sweep_checker_settle_timer.sv
// settle_timer: counts 0..SETTLE-1 while enabled and flags the last cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count at 0 (has priority over en)
//   en         : advance the count this cycle
//   expire     : high in the enabled cycle where count = SETTLE-1; this is
//                a combinational decode so the owner can act on that very edge
module settle_timer
  import func_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(SETTLE - 1);

  logic [TMR_W-1:0] count;

  assign expire = en & (count == LAST);

  // Wrap to 0 on expiry so back-to-back vectors each get SETTLE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= expire ? '0 : count + TMR_W'(1);
    end
  end

endmodule

// File: rtl/func_sweep_checker.sv
// func_sweep_checker: drives all 16 input vectors of F = A(CD + B) + BC'
// in ascending order, samples dut_f after SETTLE cycles per vector and
// scores the response against the golden table EXPECT.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a sweep (accepted in IDLE or DONE)
//   abort       : cancel a running sweep
//   dut_f       : response of the function under test
//   vec         : vector driven to the function, {A,B,C,D}
//   busy        : sweep in progress
//   done        : sweep complete, held until the next accepted start
//   pass        : valid with done, 1 when no mismatches
//   err_cnt     : number of mismatching vectors
//   first_fail  : lowest mismatching vector
//   fail_valid  : first_fail holds a captured vector
module func_sweep_checker
  import func_sweep_checker_pkg::*;
#(
  parameter int unsigned        SETTLE = 2,
  parameter logic [NUM_VEC-1:0] EXPECT = F_TRUTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_f,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail,
  output logic             fail_valid
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_t           state;
  logic             start_ok;
  logic             abort_ok;
  logic             tmr_load;
  logic             tmr_en;
  logic             expire;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;

  assign start_ok = start & (state != DRIVE);
  assign abort_ok = abort & (state == DRIVE);
  assign tmr_load = start_ok | abort_ok;
  assign tmr_en   = (state == DRIVE) & ~abort;
  assign mismatch = dut_f != EXPECT[vec];
  assign err_next = err_cnt + CNT_W'(mismatch);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (expire)
  );

  // Sweep controller, vector counter and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // start beats a simultaneous abort; abort alone does nothing here
          if (start) begin
            state      <= DRIVE;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (abort) begin
            // partial scoreboard is kept for post-mortem inspection
            state <= IDLE;
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else if (expire) begin
            err_cnt <= err_next;
            if (mismatch && !fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
            if (vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              vec <= vec + VEC_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Bench for func_sweep_checker: two instances (SETTLE=2 and SETTLE=1) drive a
// behavioural model of F with a per-sweep fault mask flipping chosen vectors.
module tb_func_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_cmd = 1'b0;
  logic       abort_cmd = 1'b0;
  logic       sel = 1'b0;
  logic [15:0] mask = 16'h0000;

  logic       start2, abort2, f2, busy2, done2, pass2, fv2;
  logic       start1, abort1, f1, busy1, done1, pass1, fv1;
  logic [3:0] vec2, ff2, vec1, ff1;
  logic [4:0] err2, err1;

  logic [3:0] o_vec, o_ff;
  logic [4:0] o_err;
  logic       o_busy, o_done, o_pass, o_fv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // F = A(CD + B) + BC' evaluated straight from the boolean expression
  function automatic logic golden(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & ((c & d) | b)) | (b & ~c);
  endfunction

  function automatic int popc(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m[i]);
    return n;
  endfunction

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  assign start2 = start_cmd & ~sel;
  assign abort2 = abort_cmd & ~sel;
  assign start1 = start_cmd & sel;
  assign abort1 = abort_cmd & sel;
  assign f2 = golden(vec2) ^ mask[vec2];
  assign f1 = golden(vec1) ^ mask[vec1];

  assign o_vec  = sel ? vec1  : vec2;
  assign o_ff   = sel ? ff1   : ff2;
  assign o_err  = sel ? err1  : err2;
  assign o_busy = sel ? busy1 : busy2;
  assign o_done = sel ? done1 : done2;
  assign o_pass = sel ? pass1 : pass2;
  assign o_fv   = sel ? fv1   : fv2;

  func_sweep_checker #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dut_f(f2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_fail(ff2), .fail_valid(fv2)
  );

  func_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_f(f1),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail(ff1), .fail_valid(fv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vec"},  32'(o_vec),  0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_pass"}, 32'(o_pass), 0);
    check({tag, "_err"},  32'(o_err),  0);
    check({tag, "_ff"},   32'(o_ff),   0);
    check({tag, "_fv"},   32'(o_fv),   0);
  endtask

  // One full sweep with fault mask m; results checked against the mask model.
  task automatic sweep(input string tag, input int s, input logic [15:0] m,
                       input bit dup, input bit with_abort);
    int bad_vec = 0;
    int bad_flags = 0;
    mask = m;
    @(negedge clk);
    start_cmd = 1'b1;
    abort_cmd = with_abort;
    @(posedge clk);
    #1;
    start_cmd = 1'b0;
    abort_cmd = 1'b0;
    check({tag, "_start_busy"}, 32'(o_busy), 1);
    check({tag, "_start_vec"},  32'(o_vec),  0);
    check({tag, "_start_done"}, 32'(o_done), 0);
    for (int c = 1; c <= 16 * s; c++) begin
      @(negedge clk);
      start_cmd = dup && (c == 3);
      @(posedge clk);
      #1;
      start_cmd = 1'b0;
      if (c < 16 * s) begin
        if (int'(o_vec) != c / s) bad_vec++;
        if (o_done || !o_busy) bad_flags++;
      end
    end
    check({tag, "_vec_seq"},  32'(bad_vec),   0);
    check({tag, "_run_flags"}, 32'(bad_flags), 0);
    check({tag, "_done"},     32'(o_done), 1);
    check({tag, "_busy"},     32'(o_busy), 0);
    check({tag, "_end_vec"},  32'(o_vec),  15);
    check({tag, "_err"},      32'(o_err),  32'(popc(m)));
    check({tag, "_ff"},       32'(o_ff),   32'(lowest(m)));
    check({tag, "_fv"},       32'(o_fv),   32'(m != 16'h0));
    check({tag, "_pass"},     32'(o_pass), 32'(m == 16'h0));
  endtask

  task automatic wait_vec(input string tag, input logic [3:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (o_vec == target) hit = 1'b1;
    end
    check({tag, "_reach"}, 32'(hit), 1);
  endtask

  logic [15:0] tied0;
  logic [15:0] m;

  initial begin
    for (int v = 0; v < 16; v++) tied0[v] = golden(4'(v));

    #23;
    sel = 1'b0;
    #1 check_idle_outputs("rst2");
    sel = 1'b1;
    #1 check_idle_outputs("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0;
    repeat (2) @(posedge clk);

    sweep("t1_good", 2, 16'h0000, 1'b0, 1'b0);
    sweep("t2_tied0", 2, tied0, 1'b0, 1'b1);
    sweep("t3_tied1", 2, ~tied0, 1'b0, 1'b0);

    sel = 1'b1;
    sweep("t4_inv11", 1, 16'h0800, 1'b0, 1'b0);
    sel = 1'b0;

    // duplicate start ignored, then abort at vec 7 keeps partial score
    m = 16'($urandom);
    mask = m;
    @(negedge clk);
    start_cmd = 1'b1;
    @(posedge clk);
    #1 start_cmd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_cmd = 1'b1;
    @(posedge clk);
    #1 start_cmd = 1'b0;
    check("t5_dup_vec", 32'(o_vec), 1);
    wait_vec("t5", 4'd7);
    @(negedge clk);
    abort_cmd = 1'b1;
    @(posedge clk);
    #1 abort_cmd = 1'b0;
    check("t5_abort_vec",  32'(o_vec),  0);
    check("t5_abort_busy", 32'(o_busy), 0);
    check("t5_abort_done", 32'(o_done), 0);
    check("t5_abort_err",  32'(o_err),  32'(popc(m & 16'h007F)));
    check("t5_abort_ff",   32'(o_ff),   32'((m & 16'h007F) != 0 ? lowest(m) : 0));
    @(negedge clk);
    abort_cmd = 1'b1;
    @(posedge clk);
    #1 abort_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("t5_idle_busy", 32'(o_busy), 0);
    sweep("t5_fresh", 2, 16'($urandom), 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom);
      m = (r % 3 == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'($urandom);
      sweep($sformatf("rnd%0d", r), sel ? 1 : 2, m, 1'($urandom), 1'($urandom));
    end

    // asynchronous reset between edges at vec 9
    sel = 1'b0;
    mask = 16'($urandom);
    @(negedge clk);
    start_cmd = 1'b1;
    @(posedge clk);
    #1 start_cmd = 1'b0;
    wait_vec("t6", 4'd9);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_idle_outputs("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
